trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Machine-mode interrupt entry/return sequencer between the CSR file and the core fetch/pipeline control.
- Watches the masked interrupt request from the CSR file and halts the pipeline with a handshake.
- Pulses the CSR capture enable so mepc/mcause/mtval latch, then redirects fetch to the handler.
- Blocks nested entry until mret, then redirects fetch back to the saved EPC.

Parameters:
- NUM_IRQ, 6: number of external interrupt lines; sets i_IRQ_VEC width.
- VECTORED, 1: 1 = target is base + 4*cause index; 0 = all causes go to base.
- ACK_TIMEOUT, 15: max cycles in DRAIN waiting for i_HALT_ACK; 0 disables the timeout.

Ports:
- i_CLK  in  1  clock.
- i_RSTn  in  1  reset, synchronous, active-low.
- i_IRQ  in  1  masked interrupt request from the CSR file (OR of enabled lines).
- i_IRQ_VEC  in  NUM_IRQ  masked per-line pending vector.
- i_IRQ_HANDLE_BASE  in  32  mtvec value.
- i_IRQ_EPC  in  32  mepc value.
- i_HALT_ACK  in  1  core: pipeline drained; i_PC/i_INSTR at CSR are the next unexecuted instruction.
- i_MRET  in  1  mret retiring this cycle.
- o_HALT  out  1  stall fetch/issue request.
- o_CSR_EN  out  1  one-cycle CSR capture strobe.
- o_PC_LOAD  out  1  one-cycle fetch redirect strobe.
- o_PC_TARGET  out  32  redirect address, valid while o_PC_LOAD=1.
- o_IRQ_ACTIVE  out  1  handler in progress.
- o_CAUSE_IDX  out  clog2(NUM_IRQ)  latched index of the interrupt being serviced.
- o_TIMEOUT  out  1  one-cycle pulse when the drain handshake times out.

Behaviour:
- All outputs are registered. Reset values: every output = 0, state = IDLE, timeout counter = 0.
- Reset mid-operation aborts immediately: outputs are 0 after the reset edge.
- State IDLE:
  - i_IRQ=1 sampled at edge N moves to DRAIN; o_HALT=1 from N+1.
  - The timeout counter clears on DRAIN entry.
- State DRAIN (o_HALT=1):
  - If i_IRQ=1 and i_HALT_ACK=1, go to CAPTURE.
  - At that edge, latch o_CAUSE_IDX = lowest set index of i_IRQ_VEC (index 0 has highest priority).
  - If i_IRQ=0 (source dropped or masked), go to IDLE and drop o_HALT. No CSR strobe is issued.
  - If ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT without ack, go to IDLE, drop o_HALT, and pulse o_TIMEOUT for 1 cycle.
  - When i_IRQ=0 and the timeout occur together, no timeout pulse is issued.
- State CAPTURE: o_CSR_EN=1 for exactly 1 cycle, o_HALT stays 1; next state is REDIRECT.
- State REDIRECT:
  - o_PC_LOAD=1 for 1 cycle, o_HALT stays 1, o_IRQ_ACTIVE=1; next state is HANDLER.
  - o_PC_TARGET = {base[31:2],2'b00} + (VECTORED ? {o_CAUSE_IDX,2'b00} : 0), computed modulo 2^32 (wraps).
  - base is sampled in the CAPTURE cycle.
- State HANDLER (o_HALT=0, o_IRQ_ACTIVE=1):
  - i_IRQ is ignored, so there is no nesting.
  - i_MRET=1 moves to RETURN.
  - When i_MRET and i_IRQ are asserted together, mret wins.
- State RETURN:
  - o_PC_LOAD=1 for 1 cycle, o_PC_TARGET = i_IRQ_EPC (sampled this cycle), o_IRQ_ACTIVE=1.
  - Next state is IDLE, where o_IRQ_ACTIVE=0.
  - A still-pending i_IRQ is accepted on the first IDLE cycle.
- i_MRET outside HANDLER is ignored.
- i_HALT_ACK outside DRAIN is ignored.
- o_PC_TARGET holds its last value while o_PC_LOAD=0.
- Minimum entry latency with i_HALT_ACK tied high: IRQ at edge N → o_CSR_EN at N+2 → o_PC_LOAD at N+3.

Test Plan:
- Reset, then i_IRQ=1 with i_IRQ_VEC=6'b000100, base=0x0000_1000, ack 3 cycles after halt → o_CSR_EN is a single pulse, then o_PC_LOAD with target 0x0000_1008, o_CAUSE_IDX=2, o_IRQ_ACTIVE=1.
- i_IRQ_VEC=6'b101010, VECTORED=0, base=0x0000_2003 → target 0x0000_2000 and o_CAUSE_IDX=1.
- In HANDLER, assert a second IRQ and then i_MRET with EPC=0x0000_0400 → no new entry; o_PC_LOAD target 0x0000_0400; re-entry starts on the first IDLE cycle while IRQ is still high.
- Hold i_HALT_ACK=0 with ACK_TIMEOUT=15 → o_TIMEOUT pulses 15 cycles after DRAIN entry, o_HALT drops, no o_CSR_EN.
- Drop i_IRQ in DRAIN before ack → IDLE, o_HALT=0, no o_CSR_EN, no o_TIMEOUT.
- Assert i_RSTn=0 during REDIRECT → all outputs 0 after the edge; i_MRET while idle produces no o_PC_LOAD.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry/return sequencer: halts the pipeline, strobes CSR capture,
// redirects fetch to the handler and back to the saved EPC on mret.
module trap_sequencer #(
   parameter int NUM_IRQ     = 6,
   parameter int VECTORED    = 1,
   parameter int ACK_TIMEOUT = 15,
   localparam int IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               i_CLK,
   input  logic               i_RSTn,
   input  logic               i_IRQ,
   input  logic [NUM_IRQ-1:0] i_IRQ_VEC,
   input  logic [31:0]        i_IRQ_HANDLE_BASE,
   input  logic [31:0]        i_IRQ_EPC,
   input  logic               i_HALT_ACK,
   input  logic               i_MRET,
   output logic               o_HALT,
   output logic               o_CSR_EN,
   output logic               o_PC_LOAD,
   output logic [31:0]        o_PC_TARGET,
   output logic               o_IRQ_ACTIVE,
   output logic [IDX_W-1:0]   o_CAUSE_IDX,
   output logic               o_TIMEOUT
);

   localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : {CNT_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_HANDLER  = 3'd4,
      ST_RETURN   = 3'd5
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      vec_off_s;
   logic [31:0]      redirect_s;

   // Index 0 has the highest priority, so scan downward and let the lowest set bit win.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] vec);
      lowest_idx = {IDX_W{1'b0}};
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            lowest_idx = IDX_W'(i);
         end
      end
   endfunction

   assign vec_off_s  = (VECTORED != 0) ? {{(30 - IDX_W){1'b0}}, o_CAUSE_IDX, 2'b00} : 32'h0000_0000;
   assign redirect_s = {i_IRQ_HANDLE_BASE[31:2], 2'b00} + vec_off_s;

   // Sequencer state, drain timeout counter and all registered outputs.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         o_HALT       <= 1'b0;
         o_CSR_EN     <= 1'b0;
         o_PC_LOAD    <= 1'b0;
         o_PC_TARGET  <= 32'h0000_0000;
         o_IRQ_ACTIVE <= 1'b0;
         o_CAUSE_IDX  <= {IDX_W{1'b0}};
         o_TIMEOUT    <= 1'b0;
      end else begin
         o_CSR_EN  <= 1'b0;
         o_PC_LOAD <= 1'b0;
         o_TIMEOUT <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_IRQ) begin
                  state_r <= ST_DRAIN;
                  o_HALT  <= 1'b1;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            ST_DRAIN: begin
               // A dropped request beats both the ack and a coincident timeout.
               if (!i_IRQ) begin
                  state_r <= ST_IDLE;
                  o_HALT  <= 1'b0;
               end else if (i_HALT_ACK) begin
                  state_r     <= ST_CAPTURE;
                  o_CSR_EN    <= 1'b1;
                  o_CAUSE_IDX <= lowest_idx(i_IRQ_VEC);
               end else if ((ACK_TIMEOUT > 0) && (cnt_r == CNT_LAST)) begin
                  state_r   <= ST_IDLE;
                  o_HALT    <= 1'b0;
                  o_TIMEOUT <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            ST_CAPTURE: begin
               state_r      <= ST_REDIRECT;
               o_PC_LOAD    <= 1'b1;
               o_PC_TARGET  <= redirect_s;
               o_IRQ_ACTIVE <= 1'b1;
            end
            ST_REDIRECT: begin
               state_r <= ST_HANDLER;
               o_HALT  <= 1'b0;
            end
            ST_HANDLER: begin
               if (i_MRET) begin
                  state_r     <= ST_RETURN;
                  o_PC_LOAD   <= 1'b1;
                  o_PC_TARGET <= i_IRQ_EPC;
               end
            end
            ST_RETURN: begin
               state_r      <= ST_IDLE;
               o_IRQ_ACTIVE <= 1'b0;
            end
            default: begin
               state_r      <= ST_IDLE;
               o_HALT       <= 1'b0;
               o_IRQ_ACTIVE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized episode-level bench for trap_sequencer; a vectored and a non-vectored instance
// share stimulus and are checked every cycle against offsets predicted by the bench.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq;
   logic [5:0]  vec;
   logic [31:0] base;
   logic [31:0] epc;
   logic        ack;
   logic        mret;

   logic        v_halt, v_csr, v_pcl, v_act, v_to;
   logic [31:0] v_tgt;
   logic [2:0]  v_cause;
   logic        n_halt, n_csr, n_pcl, n_act, n_to;
   logic [31:0] n_tgt;
   logic [2:0]  n_cause;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_tgt_v;
   logic [31:0] exp_tgt_n;
   logic [31:0] exp_cause;

   always #5 clk = ~clk;

   trap_sequencer #(.NUM_IRQ(6), .VECTORED(1), .ACK_TIMEOUT(15)) dut_v (
      .i_CLK(clk), .i_RSTn(rst_n), .i_IRQ(irq), .i_IRQ_VEC(vec),
      .i_IRQ_HANDLE_BASE(base), .i_IRQ_EPC(epc), .i_HALT_ACK(ack), .i_MRET(mret),
      .o_HALT(v_halt), .o_CSR_EN(v_csr), .o_PC_LOAD(v_pcl), .o_PC_TARGET(v_tgt),
      .o_IRQ_ACTIVE(v_act), .o_CAUSE_IDX(v_cause), .o_TIMEOUT(v_to)
   );

   trap_sequencer #(.NUM_IRQ(6), .VECTORED(0), .ACK_TIMEOUT(15)) dut_n (
      .i_CLK(clk), .i_RSTn(rst_n), .i_IRQ(irq), .i_IRQ_VEC(vec),
      .i_IRQ_HANDLE_BASE(base), .i_IRQ_EPC(epc), .i_HALT_ACK(ack), .i_MRET(mret),
      .o_HALT(n_halt), .o_CSR_EN(n_csr), .o_PC_LOAD(n_pcl), .o_PC_TARGET(n_tgt),
      .o_IRQ_ACTIVE(n_act), .o_CAUSE_IDX(n_cause), .o_TIMEOUT(n_to)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Isolate the lowest set bit, then its index is the number of ones below it.
   function automatic logic [31:0] low_index(input logic [5:0] v);
      logic [5:0] iso;
      iso = v & (~v + 6'd1);
      return 32'($countones(iso - 6'd1));
   endfunction

   task automatic tick_chk(input logic e_halt, input logic e_csr, input logic e_pcl,
                           input logic e_act, input logic e_to);
      @(posedge clk);
      #1;
      check_val("halt",      {31'd0, v_halt}, {31'd0, e_halt});
      check_val("halt_nv",   {31'd0, n_halt}, {31'd0, e_halt});
      check_val("csr_en",    {31'd0, v_csr},  {31'd0, e_csr});
      check_val("csr_en_nv", {31'd0, n_csr},  {31'd0, e_csr});
      check_val("pc_load",   {31'd0, v_pcl},  {31'd0, e_pcl});
      check_val("pc_load_nv",{31'd0, n_pcl},  {31'd0, e_pcl});
      check_val("active",    {31'd0, v_act},  {31'd0, e_act});
      check_val("active_nv", {31'd0, n_act},  {31'd0, e_act});
      check_val("timeout",   {31'd0, v_to},   {31'd0, e_to});
      check_val("timeout_nv",{31'd0, n_to},   {31'd0, e_to});
      check_val("target",    v_tgt, exp_tgt_v);
      check_val("target_nv", n_tgt, exp_tgt_n);
      check_val("cause",     {29'd0, v_cause}, exp_cause);
      check_val("cause_nv",  {29'd0, n_cause}, exp_cause);
   endtask

   // Full entry -> handler -> mret -> return; d = idle-ack cycles after halt, hl = handler length.
   task automatic do_entry(input logic [5:0] v, input logic [31:0] b, input int d, input int hl,
                           input logic [31:0] e, input logic irq_after);
      irq = 1'b1; vec = v; base = b; ack = 1'b0; mret = 1'($urandom_range(1, 0));
      tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < d; k++) begin
         mret = 1'($urandom_range(1, 0));
         tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      ack = 1'b1;
      exp_cause = low_index(v);
      tick_chk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ack = 1'($urandom_range(1, 0)); irq = 1'($urandom_range(1, 0));
      exp_tgt_v = (b & 32'hFFFF_FFFC) + 32'(4 * exp_cause);
      exp_tgt_n = b & 32'hFFFF_FFFC;
      tick_chk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      base = $urandom; mret = 1'($urandom_range(1, 0));
      tick_chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < hl; k++) begin
         mret = 1'b0; irq = 1'($urandom_range(1, 0)); ack = 1'($urandom_range(1, 0));
         tick_chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      mret = 1'b1; irq = 1'($urandom_range(1, 0)); epc = e;
      exp_tgt_v = e; exp_tgt_n = e;
      tick_chk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      mret = 1'($urandom_range(1, 0)); epc = $urandom; irq = irq_after; ack = 1'b0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mret = 1'b0;
   endtask

   task automatic do_timeout();
      irq = 1'b1; ack = 1'b0; vec = 6'(($urandom_range(62, 0)) + 1);
      tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k < 15; k++) begin
         mret = 1'($urandom_range(1, 0));
         tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      irq = 1'b0; mret = 1'b0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_drop(input int d);
      irq = 1'b1; ack = 1'b0;
      tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < d; k++) begin
         tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      irq = 1'b0; ack = 1'($urandom_range(1, 0));
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ack = 1'b0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset lands while the core is being redirected; then an mret in idle must do nothing.
   task automatic do_reset_in_redirect(input logic [5:0] v, input logic [31:0] b);
      irq = 1'b1; vec = v; base = b; ack = 1'b1;
      tick_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_cause = low_index(v);
      tick_chk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ack = 1'b0;
      exp_tgt_v = (b & 32'hFFFF_FFFC) + 32'(4 * exp_cause);
      exp_tgt_n = b & 32'hFFFF_FFFC;
      tick_chk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      exp_tgt_v = 32'h0; exp_tgt_n = 32'h0; exp_cause = 32'h0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; irq = 1'b0; mret = 1'b1;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mret = 1'b0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; irq = 1'b0; vec = 6'd0; base = 32'h0; epc = 32'h0; ack = 1'b0; mret = 1'b0;
      exp_tgt_v = 32'h0; exp_tgt_n = 32'h0; exp_cause = 32'h0;
      irq = 1'b1; ack = 1'b1; mret = 1'b1;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; irq = 1'b0; ack = 1'b0; mret = 1'b0;
      tick_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      do_entry(6'b000100, 32'h0000_1000, 3, 2, 32'h0000_0400, 1'b1);
      check_val("tp_cause2", {29'd0, v_cause}, 32'd2);
      do_entry(6'b101010, 32'h0000_2003, 0, 1, 32'h0000_0400, 1'b0);
      do_entry(6'b100000, 32'hFFFF_FFFC, 14, 0, 32'h8000_0000, 1'b0);
      do_timeout();
      do_drop(3);
      do_drop(14);
      do_drop(0);
      do_reset_in_redirect(6'b011000, 32'h0000_3000);

      for (int ep = 0; ep < 60; ep++) begin
         int sel;
         sel = $urandom_range(99, 0);
         if (sel < 60) begin
            do_entry(6'($urandom_range(62, 0) + 1), $urandom, $urandom_range(14, 0),
                     $urandom_range(4, 0), $urandom, 1'($urandom_range(1, 0)));
         end else if (sel < 72) begin
            do_timeout();
         end else if (sel < 88) begin
            do_drop($urandom_range(14, 0));
         end else begin
            do_reset_in_redirect(6'($urandom_range(62, 0) + 1), $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
